// File: rtl/mii_rx_frame_parser.sv
// MII receive front end: strips preamble/SFD, packs nibbles into bytes (low nibble first)
// and emits a framed byte stream with sop/eop, length, error flag and a dropped-frame count.
module mii_rx_frame_parser #(
    parameter int MIN_PRE   = 7,
    parameter int MAX_BYTES = 1522,
    parameter int LEN_W     = 11
) (
    input  logic             rxc_i,
    input  logic             rst_n_i,
    input  logic [3:0]       rxd_i,
    input  logic             rxdv_i,
    output logic [7:0]       rx_data_o,
    output logic             rx_valid_o,
    output logic             rx_sop_o,
    output logic             rx_eop_o,
    output logic             rx_err_o,
    output logic [LEN_W-1:0] rx_len_o,
    output logic [15:0]      drop_cnt_o
);

    localparam logic [3:0]       NIB_PRE   = 4'h5;
    localparam logic [3:0]       NIB_SFD   = 4'hd;
    localparam logic [3:0]       MIN_PRE_C = 4'(MIN_PRE);
    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_BYTES);

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       preCnt_q, preCnt_d;
    logic             phase_q, phase_d;
    logic [3:0]       lowNib_q, lowNib_d;
    logic [7:0]       hold_q, hold_d;
    logic             holdFull_q, holdFull_d;
    logic             sopPend_q, sopPend_d;
    logic [LEN_W-1:0] byteCnt_q, byteCnt_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             sop_q, sop_d;
    logic             eop_q, eop_d;
    logic             err_q, err_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [15:0]      dropCnt_q, dropCnt_d;
    logic             dropInc;

    always_ff @(posedge rxc_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            preCnt_q   <= '0;
            phase_q    <= 1'b0;
            lowNib_q   <= '0;
            hold_q     <= '0;
            holdFull_q <= 1'b0;
            sopPend_q  <= 1'b0;
            byteCnt_q  <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            err_q      <= 1'b0;
            len_q      <= '0;
            dropCnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            preCnt_q   <= preCnt_d;
            phase_q    <= phase_d;
            lowNib_q   <= lowNib_d;
            hold_q     <= hold_d;
            holdFull_q <= holdFull_d;
            sopPend_q  <= sopPend_d;
            byteCnt_q  <= byteCnt_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            sop_q      <= sop_d;
            eop_q      <= eop_d;
            err_q      <= err_d;
            len_q      <= len_d;
            dropCnt_q  <= dropCnt_d;
        end
    end

    // One byte is always held back so the final byte can be tagged with eop when rxdv falls.
    always_comb begin
        state_d    = state_q;
        preCnt_d   = preCnt_q;
        phase_d    = phase_q;
        lowNib_d   = lowNib_q;
        hold_d     = hold_q;
        holdFull_d = holdFull_q;
        sopPend_d  = sopPend_q;
        byteCnt_d  = byteCnt_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        sop_d      = 1'b0;
        eop_d      = 1'b0;
        err_d      = err_q;
        len_d      = len_q;
        dropInc    = 1'b0;

        case (state_q)
            IDLE: begin
                if (rxdv_i) begin
                    if (rxd_i == NIB_PRE) begin
                        state_d  = PREAMBLE;
                        preCnt_d = 4'd1;
                    end else begin
                        state_d = DROP;
                        dropInc = 1'b1;
                    end
                end
            end
            PREAMBLE: begin
                if (!rxdv_i) begin
                    state_d = IDLE;
                end else if (rxd_i == NIB_PRE) begin
                    preCnt_d = (preCnt_q == 4'hF) ? preCnt_q : preCnt_q + 4'd1;
                end else if (rxd_i == NIB_SFD && preCnt_q >= MIN_PRE_C) begin
                    state_d    = DATA;
                    phase_d    = 1'b0;
                    byteCnt_d  = '0;
                    holdFull_d = 1'b0;
                    sopPend_d  = 1'b1;
                end else begin
                    state_d = DROP;
                    dropInc = 1'b1;
                end
            end
            DATA: begin
                if (rxdv_i) begin
                    if (!phase_q) begin
                        lowNib_d = rxd_i;
                        phase_d  = 1'b1;
                    end else begin
                        phase_d    = 1'b0;
                        hold_d     = {rxd_i, lowNib_q};
                        holdFull_d = 1'b1;
                        byteCnt_d  = (byteCnt_q == '1) ? byteCnt_q : byteCnt_q + 1'b1;
                        if (holdFull_q) begin
                            data_d    = hold_q;
                            valid_d   = 1'b1;
                            sop_d     = sopPend_q;
                            sopPend_d = 1'b0;
                        end
                    end
                end else begin
                    state_d    = IDLE;
                    phase_d    = 1'b0;
                    holdFull_d = 1'b0;
                    sopPend_d  = 1'b0;
                    if (holdFull_q) begin
                        data_d  = hold_q;
                        valid_d = 1'b1;
                        eop_d   = 1'b1;
                        sop_d   = sopPend_q;
                        len_d   = byteCnt_q;
                        err_d   = phase_q || (byteCnt_q > MAX_LEN_C);
                    end else begin
                        dropInc = 1'b1;
                    end
                end
            end
            DROP: begin
                if (!rxdv_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        dropCnt_d = (dropInc && dropCnt_q != 16'hFFFF) ? dropCnt_q + 16'd1 : dropCnt_q;
    end

    assign rx_data_o  = data_q;
    assign rx_valid_o = valid_q;
    assign rx_sop_o   = sop_q;
    assign rx_eop_o   = eop_q;
    assign rx_err_o   = err_q;
    assign rx_len_o   = len_q;
    assign drop_cnt_o = dropCnt_q;

endmodule

// File: tb/tb_mii_rx_frame_parser.sv
// Directed bench for mii_rx_frame_parser: drives nibble frames and checks the recorded
// byte stream against the payload nibbles the bench generated.
module tb_mii_rx_frame_parser;

    localparam int DEPTH = 16384;

    logic        rxc;
    logic        rst_n;
    logic [3:0]  rxd;
    logic        rxdv;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_sop;
    logic        rx_eop;
    logic        rx_err;
    logic [10:0] rx_len;
    logic [15:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    logic [3:0]  nibs [3200];
    logic [7:0]  recData [DEPTH];
    logic        recSop [DEPTH];
    logic        recEop [DEPTH];
    logic        recErr [DEPTH];
    logic [10:0] recLen [DEPTH];
    int          recCyc [DEPTH];
    int          recCount = 0;
    int          cycle = 0;

    mii_rx_frame_parser #(
        .MIN_PRE   (7),
        .MAX_BYTES (1522),
        .LEN_W     (11)
    ) dut (
        .rxc_i      (rxc),
        .rst_n_i    (rst_n),
        .rxd_i      (rxd),
        .rxdv_i     (rxdv),
        .rx_data_o  (rx_data),
        .rx_valid_o (rx_valid),
        .rx_sop_o   (rx_sop),
        .rx_eop_o   (rx_eop),
        .rx_err_o   (rx_err),
        .rx_len_o   (rx_len),
        .drop_cnt_o (drop_cnt)
    );

    initial rxc = 1'b0;
    always #5 rxc = ~rxc;

    // Every byte the DUT delivers is logged with its flags and the cycle it appeared in.
    always @(negedge rxc) begin
        cycle <= cycle + 1;
        if (rx_valid) begin
            recData[recCount % DEPTH] <= rx_data;
            recSop[recCount % DEPTH]  <= rx_sop;
            recEop[recCount % DEPTH]  <= rx_eop;
            recErr[recCount % DEPTH]  <= rx_err;
            recLen[recCount % DEPTH]  <= rx_len;
            recCyc[recCount % DEPTH]  <= cycle;
            recCount <= recCount + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic driveNib(input logic [3:0] n, input logic dv);
        @(posedge rxc);
        #2;
        rxd  = n;
        rxdv = dv;
    endtask

    task automatic fillRandom(input int n);
        for (int i = 0; i < n; i++) nibs[i] = 4'($urandom_range(15, 0));
    endtask

    task automatic applyStimulus(input int nPre, input int nPay);
        for (int i = 0; i < nPre; i++) driveNib(4'h5, 1'b1);
        driveNib(4'hd, 1'b1);
        for (int i = 0; i < nPay; i++) driveNib(nibs[i], 1'b1);
        repeat (4) driveNib(4'h0, 1'b0);
    endtask

    task automatic checkFrame(input string tag, input int base, input int expN,
                              input int expLen, input logic expErr);
        int got, n, bad, sops, eops, gapBad, idx, last;
        got = recCount - base;
        checkOutput({tag, ".count"}, got, expN);
        n = (got < expN) ? got : expN;
        bad = 0; sops = 0; eops = 0; gapBad = 0;
        for (int k = 0; k < n; k++) begin
            idx = (base + k) % DEPTH;
            if (recData[idx] !== {nibs[2*k+1], nibs[2*k]}) bad++;
            if (recSop[idx]) sops++;
            if (recEop[idx]) eops++;
            if (k > 0 && k < n - 1 && recCyc[idx] - recCyc[(idx + DEPTH - 1) % DEPTH] != 2) gapBad++;
        end
        checkOutput({tag, ".badBytes"}, bad, 0);
        checkOutput({tag, ".sopCount"}, sops, 1);
        checkOutput({tag, ".eopCount"}, eops, 1);
        checkOutput({tag, ".gaps"}, gapBad, 0);
        if (got > 0) begin
            last = (base + got - 1) % DEPTH;
            checkOutput({tag, ".firstSop"}, recSop[base % DEPTH], 1);
            checkOutput({tag, ".lastEop"}, recEop[last], 1);
            checkOutput({tag, ".len"}, recLen[last], expLen);
            checkOutput({tag, ".err"}, recErr[last], expErr);
        end
    endtask

    initial begin
        int base;
        int reached;
        int eops;

        rst_n = 1'b0;
        rxd   = 4'h0;
        rxdv  = 1'b0;
        repeat (3) @(posedge rxc);
        #2;
        checkOutput("reset.valid", rx_valid, 0);
        checkOutput("reset.sop", rx_sop, 0);
        checkOutput("reset.eop", rx_eop, 0);
        checkOutput("reset.err", rx_err, 0);
        checkOutput("reset.data", rx_data, 0);
        checkOutput("reset.len", rx_len, 0);
        checkOutput("reset.drop", drop_cnt, 0);
        rst_n = 1'b1;
        repeat (3) driveNib(4'h0, 1'b0);

        $display("[TB] nominal frame");
        fillRandom(1300);
        base = recCount;
        applyStimulus(15, 1300);
        checkFrame("nominal", base, 650, 650, 1'b0);
        checkOutput("nominal.drop", drop_cnt, 0);

        $display("[TB] back-to-back frames");
        for (int f = 0; f < 10; f++) begin
            fillRandom(1300);
            base = recCount;
            applyStimulus(15, 1300);
            checkFrame($sformatf("b2b%0d", f), base, 650, 650, 1'b0);
            repeat (500) driveNib(4'h0, 1'b0);
        end
        checkOutput("b2b.drop", drop_cnt, 0);

        $display("[TB] short preamble");
        fillRandom(100);
        base = recCount;
        applyStimulus(6, 100);
        checkOutput("shortPre.count", recCount - base, 0);
        checkOutput("shortPre.drop", drop_cnt, 1);

        $display("[TB] odd nibble count");
        fillRandom(201);
        base = recCount;
        applyStimulus(7, 201);
        checkFrame("odd", base, 100, 100, 1'b1);
        checkOutput("odd.drop", drop_cnt, 1);

        $display("[TB] edge frames");
        fillRandom(2);
        base = recCount;
        applyStimulus(7, 2);
        checkFrame("oneByte", base, 1, 1, 1'b0);

        base = recCount;
        applyStimulus(7, 0);
        checkOutput("empty.count", recCount - base, 0);
        checkOutput("empty.drop", drop_cnt, 2);

        fillRandom(3044);
        base = recCount;
        applyStimulus(7, 3044);
        checkFrame("max", base, 1522, 1522, 1'b0);

        fillRandom(3046);
        base = recCount;
        applyStimulus(7, 3046);
        checkFrame("tooLong", base, 1523, 1523, 1'b1);
        checkOutput("tooLong.drop", drop_cnt, 2);

        $display("[TB] reset mid-frame");
        fillRandom(1300);
        base = recCount;
        reached = 0;
        for (int i = 0; i < 15; i++) driveNib(4'h5, 1'b1);
        driveNib(4'hd, 1'b1);
        for (int i = 0; i < 1300; i++) begin
            driveNib(nibs[i], 1'b1);
            if (recCount - base >= 101) begin
                reached = 1;
                break;
            end
        end
        checkOutput("rst.reached", reached, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst.valid", rx_valid, 0);
        checkOutput("rst.data", rx_data, 0);
        checkOutput("rst.len", rx_len, 0);
        checkOutput("rst.err", rx_err, 0);
        checkOutput("rst.drop", drop_cnt, 0);
        repeat (3) driveNib(4'h3, 1'b1);
        driveNib(4'ha, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) driveNib(4'($urandom_range(15, 0)), 1'b1);
        repeat (4) driveNib(4'h0, 1'b0);
        eops = 0;
        for (int k = base; k < recCount; k++) if (recEop[k % DEPTH]) eops++;
        checkOutput("rst.noEop", eops, 0);
        checkOutput("rst.bytes", recCount - base, 101);
        checkOutput("rst.dropAfter", drop_cnt, 1);

        fillRandom(1300);
        base = recCount;
        applyStimulus(15, 1300);
        checkFrame("postRst", base, 650, 650, 1'b0);
        checkOutput("postRst.drop", drop_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mii_rx_frame_parser.md
Name: mii_rx_frame_parser

Overview:
Receive-side front end that consumes the 4-bit MII nibble stream (rxd/rxdv on rxc) and feeds the downstream frame stage. It strips the preamble and SFD and packs nibbles into bytes, low nibble first. It emits a byte stream with start-of-packet and end-of-packet markers, the frame length and an error flag. Frames that fail the preamble/SFD check, or carry no payload, are dropped and counted.

Parameters:
MIN_PRE, 7, minimum number of 4'h5 nibbles that must precede 4'hd for the frame to be accepted.
MAX_BYTES, 1522, frames longer than this are delivered, but with rx_err=1 on eop.
LEN_W, 11, width of rx_len; the internal byte count saturates at 2^LEN_W-1.

Ports:
rxc  in  1  receive clock; all logic is on the rising edge.
rst_n  in  1  asynchronous active-low reset.
rxd  in  4  MII receive nibble.
rxdv  in  1  MII receive data valid.
rx_data  out  8  assembled byte.
rx_valid  out  1  one-cycle strobe; rx_data is valid.
rx_sop  out  1  qualifies the first byte of a frame (only with rx_valid).
rx_eop  out  1  qualifies the last byte of a frame (only with rx_valid).
rx_err  out  1  frame error; valid only with rx_eop.
rx_len  out  LEN_W  frame byte count; valid only with rx_eop.
drop_cnt  out  16  saturating count of dropped frames.

Behaviour:
- Reset: every output is 0, the state is IDLE, and the pre-count, nibble phase, hold register and byte count are all cleared.
- IDLE state:
  - rxdv=1 and rxd=5: go to PREAMBLE with pre_cnt=1.
  - rxdv=1 and rxd!=5: go to DROP.
- PREAMBLE state:
  - rxdv=0: go to IDLE; drop_cnt is unchanged (a carrier with no SFD is not counted).
  - rxd=5: pre_cnt increments, saturating at 15.
  - rxd=d and pre_cnt>=MIN_PRE: go to DATA with phase=0 and byte count 0.
  - rxd=d and pre_cnt<MIN_PRE: go to DROP.
  - Any other nibble: go to DROP.
- DATA state, rxdv=1:
  - Phase 0: latch the low nibble.
  - Phase 1: form the byte {rxd, low}. If the hold register is full, move the held byte to rx_data with rx_valid=1 in the next cycle. Then load the new byte into the hold register and increment the byte count.
  - One-byte holdback: byte N appears 1 cycle after the edge that sampled the high nibble of byte N+1. Bytes are therefore spaced 2 cycles apart.
  - rx_sop=1 on the first emitted byte of the frame.
- DATA state, rxdv=0 sampled:
  - If the hold register is full: emit the held byte with rx_valid=1 and rx_eop=1, and with rx_sop=1 as well if it is the only byte. rx_len is the byte count.
  - rx_err=1 if phase=1 (odd nibble count; the trailing nibble is discarded) or if the count > MAX_BYTES.
  - If the hold register is empty (SFD followed immediately by rxdv=0, or a single trailing nibble only): no output, drop_cnt increments.
  - In all cases, go to IDLE.
- DROP state: on entry, drop_cnt increments (saturating at 16'hFFFF). The state stays in DROP while rxdv=1 and goes to IDLE on rxdv=0.
- rx_valid, rx_sop and rx_eop are single-cycle pulses. rx_data, rx_len and rx_err hold their values until the next rx_valid.
- Reset asserted mid-frame: outputs clear immediately and no eop is generated for the truncated frame. If rxdv is still high after release, IDLE applies its normal rules; payload nibbles that are not 5 lead to DROP.
- A frame may start again in the cycle directly after rxdv=0 is sampled; the IDLE rules apply to that next sample.

Test Plan:
- Nominal frame: rxdv=1, 15x 4'h5, 4'hd, 1300 random nibbles, rxdv=0 → 650 rx_valid pulses 2 cycles apart. Bytes are {n(2k+1), n(2k)}. sop on byte 0, eop on byte 649, rx_len=650, rx_err=0, drop_cnt=0.
- Ten back-to-back nominal frames with 500 idle cycles between them → 10 sop/eop pairs, each rx_len=650, drop_cnt=0.
- Short preamble: 6x 5 then d, then 100 nibbles → no rx_valid, drop_cnt=1.
- Odd nibble count: 7x 5, d, 201 nibbles → 100 bytes, eop with rx_len=100 and rx_err=1.
- Edge frames:
  - 7x 5, d, 2 nibbles → one byte with sop=eop=1, rx_len=1.
  - 7x 5, d, rxdv=0 → no output, drop_cnt increments.
  - 3046 nibbles → rx_len=1523, rx_err=1.
- Reset mid-frame: assert rst_n=0 after byte 100 of a nominal frame → outputs 0 at once, no eop. After release with rxdv still high on random data → DROP, drop_cnt=1. The next clean frame is received correctly.
